uart_pkt_tx: RTL and testbench
==============================

# uart_pkt_tx

- Packet-framing transmitter: the transmit-side counterpart of the idle-gap packet receiver.
- Buffers one packet of bytes from a producer and streams them, in order, to the `uart_tx` byte transmitter through its `tx_start`/`tx_busy` handshake.
- After the last byte, holds the line idle for a guaranteed gap so the far-end idle detector raises end-of-packet, then pulses `pkt_done`.
- Sits between packet-producing logic and `uart_tx`, in the PLL clock domain.

## Interface
- `CLK_FREQ`, 42_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer division (364 at defaults).
- `DEPTH`, 48: buffer capacity in bytes (2..64).
- `GAP_BITS`, 20: idle gap after a packet, in bit-times.

- `clk` in 1: system clock (PLL output).
- `rst_n` in 1: reset. Synchronous, active-low.
- `wr_en` in 1: producer write strobe.
- `wr_data` in 8: byte to buffer.
- `wr_last` in 1: qualifies `wr_en`; this byte ends the packet.
- `wr_ready` out 1: buffer accepts a write this cycle.
- `tx_start` out 1: start request to `uart_tx`.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_busy` in 1: `uart_tx` busy.
- `pkt_done` out 1: one-cycle pulse when the packet and its gap are complete.
- `busy` out 1: high whenever state is not FILL.

## Operation
- States: FILL, REQ, ACK, DRAIN, GAP.

**FILL**
- `wr_ready = (count < LIMIT)`. `LIMIT = DEPTH`, or `DEPTH-1` when the checksum feature is built in.
- A write is accepted when `wr_en && wr_ready`. The accepted byte is stored at `buf[count]` and `count` increments.
- Commit happens on an accepted write with `wr_last=1`, or on the write that makes `count == LIMIT` (forced commit; `wr_last` is implied).
- On commit: go to REQ, set `rd_idx = 0`.
- A zero-length packet cannot occur.

**REQ**
- `tx_data = byte[rd_idx]`.
- `tx_start = 1` only while `tx_busy = 0`.
- `tx_busy = 1` with `tx_start = 1`: go to ACK.
- If `tx_busy` is already high on entry, `tx_start` stays 0 and the block waits.

**ACK**
- `tx_start = 0`.
- When `tx_busy` falls: go to DRAIN.

**DRAIN**
- If `rd_idx` is the last byte: go to GAP and load the gap counter with `GAP_BITS*CLKS_PER_BIT - 1`.
- Otherwise: increment `rd_idx` and go to REQ.

**GAP**
- Decrement the counter each cycle.
- At 0: assert `pkt_done` for one cycle, clear `count`, go to FILL.

**General rules**
- Writes outside FILL are ignored: `wr_ready = 0`, no state change.
- `tx_data` holds its value between requests and changes only in REQ.

## Timing
**Reset values** (`rst_n` low at a `clk` edge; takes effect at that edge, from any state):
- `wr_ready = 1`, `tx_start = 0`, `tx_data = 0x00`, `pkt_done = 0`, `busy = 0`.
- State FILL, `count = 0`; buffer contents discarded.
- Reset mid-transmission drops `tx_start` at that edge. The byte already in `uart_tx` completes on the line; no gap and no `pkt_done` follow.

**Cycle timing**
- The committing write at edge N puts the block in REQ at N+1. `tx_start` is registered high at N+2 if `tx_busy` was low at N+1.
- `tx_start` deasserts on the edge after `tx_busy` is first sampled high.
- `pkt_done` rises exactly `GAP_BITS*CLKS_PER_BIT + 1` cycles after the edge where the last byte's `tx_busy` is sampled low.
- `wr_ready` rises in the same cycle `pkt_done` is high. The next packet's first write is accepted on the following edge.
- All outputs are registered except `wr_ready` and `busy`, which decode state/count combinationally.

## Configuration
- `UART_PKT_TX_CHKSUM_EN` defined:
  - After the last payload byte, one extra byte is sent: the XOR of all payload bytes.
  - The XOR accumulator is updated on each accepted write and cleared on commit-to-FILL and on reset.
  - Payload is limited to `DEPTH-1` bytes; the forced commit occurs at `DEPTH-1`.
- Not defined:
  - Only payload bytes are sent; `LIMIT = DEPTH`.
  - No accumulator logic is present.

## Test plan
- **Three-byte packet.** Write 0x41, 0x42, 0x43 (`wr_last` on 0x43), with a `uart_tx` model that holds busy for 10*364 cycles.
  - Three handshakes carry 0x41/0x42/0x43 in order.
  - `pkt_done` pulses once, 7281 cycles after the last busy fall.
  - `wr_ready` is 0 throughout sending.
- **Forced commit.** 48 writes of 0x00..0x2F with `wr_last` never set (checksum off).
  - The 48th write commits and `wr_ready` drops.
  - 48 bytes are sent in order.
- **Writes while busy.** Pulse `wr_en` with 0xFF during REQ, ACK and GAP.
  - The writes are ignored; the sent bytes and the next packet contents are unaffected.
- **Busy held at send start.** `tx_busy` is held high for 100 cycles at REQ entry.
  - `tx_start` stays 0 until `tx_busy` is low, then asserts on the following edge.
- **Reset mid-packet.** `rst_n` low for 1 cycle during the second byte's ACK.
  - All outputs return to reset values.
  - No `pkt_done`.
  - The next packet 0x55 transmits normally.
- **Checksum (`UART_PKT_TX_CHKSUM_EN`).** Write 0x01, 0x02, 0x04 (`wr_last` on 0x04).
  - Four bytes are sent: 0x01, 0x02, 0x04, 0x07.
  - 47 unterminated writes force a commit and send 48 bytes.

Source files
------------

// File: rtl/uart_pkt_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkt_tx
// Purpose  : Packet-framing transmitter. Buffers one packet of bytes from a
//            producer, streams them in order to a uart_tx byte transmitter
//            over its tx_start/tx_busy handshake, then holds the line idle
//            for GAP_BITS bit-times so the far-end idle detector closes the
//            packet, and finally pulses pkt_done.
// Ports    : clk       - system clock (PLL domain)
//            rst_n     - synchronous active-low reset
//            wr_en     - producer write strobe
//            wr_data   - byte to buffer
//            wr_last   - marks the byte that ends the packet
//            wr_ready  - buffer accepts a write this cycle (combinational)
//            tx_start  - start request to uart_tx (registered)
//            tx_data   - byte to uart_tx (registered)
//            tx_busy   - uart_tx busy
//            pkt_done  - one-cycle pulse when packet and gap are complete
//            busy      - high whenever the block is not filling (combinational)
// Options  : UART_PKT_TX_CHKSUM_EN - append the XOR of all payload bytes as an
//            extra trailing byte; payload capacity becomes DEPTH-1.
// Revision : 1.0 - initial release
// ============================================================================
module uart_pkt_tx #(
  parameter int CLK_FREQ = 42_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 48,
  parameter int GAP_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       pkt_done,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int GAP_LOAD     = GAP_BITS * CLKS_PER_BIT - 1;
  localparam int GW           = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;
  localparam int CW           = $clog2(DEPTH + 1);
  localparam int AW           = $clog2(DEPTH);
`ifdef UART_PKT_TX_CHKSUM_EN
  localparam int LIMIT        = DEPTH - 1;
`else
  localparam int LIMIT        = DEPTH;
`endif

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_idx;
  logic [CW-1:0] w_last_idx;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_buf [DEPTH];
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_accept;
  logic          w_commit;
  logic          w_last_byte;
  logic          w_gap_zero;
  logic [7:0]    w_cur_byte;
  logic          w_tx_start_nxt;
  logic [7:0]    w_tx_data_nxt;
  logic          w_pkt_done_nxt;

  // --------------------------------------------------------------------------
  // Combinational decodes
  // --------------------------------------------------------------------------
  assign wr_ready    = (r_state == S_FILL) && (r_count < CW'(LIMIT));
  assign busy        = (r_state != S_FILL);
  assign w_accept    = wr_en && wr_ready;
  // The write that fills the buffer commits even without wr_last.
  assign w_commit    = w_accept && (wr_last || (r_count == CW'(LIMIT - 1)));
  assign w_wr_addr   = r_count[AW-1:0];
  assign w_rd_addr   = r_rd_idx[AW-1:0];
  assign w_last_byte = (r_rd_idx == w_last_idx);
  assign w_gap_zero  = (r_gap_cnt == '0);

`ifdef UART_PKT_TX_CHKSUM_EN
  logic [7:0] r_chk;

  // The checksum occupies the slot just past the payload.
  assign w_last_idx = r_count;
  assign w_cur_byte = (r_rd_idx == r_count) ? r_chk : r_buf[w_rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chk <= 8'h00;
    end else if ((r_state == S_GAP) && w_gap_zero) begin
      r_chk <= 8'h00;
    end else if (w_accept) begin
      r_chk <= r_chk ^ wr_data;
    end
  end
`else
  assign w_last_idx = r_count - CW'(1);
  assign w_cur_byte = r_buf[w_rd_addr];
`endif

  // --------------------------------------------------------------------------
  // Packet buffer (no reset: contents are meaningless outside a packet)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_buf[w_wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // State register, registered outputs and datapath counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_count   <= '0;
      r_rd_idx  <= '0;
      r_gap_cnt <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      pkt_done  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      tx_start <= w_tx_start_nxt;
      tx_data  <= w_tx_data_nxt;
      pkt_done <= w_pkt_done_nxt;

      if (w_accept) begin
        r_count <= r_count + CW'(1);
      end

      case (r_state)
        S_FILL: begin
          if (w_commit) begin
            r_rd_idx <= '0;
          end
        end
        S_DRAIN: begin
          if (w_last_byte) begin
            r_gap_cnt <= GW'(GAP_LOAD);
          end else begin
            r_rd_idx <= r_rd_idx + CW'(1);
          end
        end
        S_GAP: begin
          if (w_gap_zero) begin
            r_count <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_commit)             w_state_nxt = S_REQ;
      // Handshake seen: our registered start is up and uart_tx went busy.
      S_REQ:   if (tx_start && tx_busy)  w_state_nxt = S_ACK;
      S_ACK:   if (!tx_busy)             w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = w_last_byte ? S_GAP : S_REQ;
      S_GAP:   if (w_gap_zero)           w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = tx_data;
    w_pkt_done_nxt = 1'b0;
    case (r_state)
      S_REQ: begin
        // Request only while uart_tx is idle; this also drops start on the
        // edge after busy is first seen.
        w_tx_data_nxt  = w_cur_byte;
        w_tx_start_nxt = !tx_busy;
      end
      S_GAP: begin
        w_pkt_done_nxt = w_gap_zero;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_pkt_tx
// Purpose  : Self-checking bench for uart_pkt_tx with a behavioural uart_tx
//            responder and a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_pkt_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 48;
  localparam int GAP_BITS = 20;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int GAP_CYC  = GAP_BITS * CPB;
  localparam int TIMEOUT  = 20000;
`ifdef UART_PKT_TX_CHKSUM_EN
  localparam int LIMIT    = DEPTH - 1;
`else
  localparam int LIMIT    = DEPTH;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       pkt_done;
  logic       busy;

  uart_pkt_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .DEPTH   (DEPTH),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_last (wr_last),
    .wr_ready(wr_ready),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .pkt_done(pkt_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural uart_tx: takes a byte when start is seen while idle, then
  // stays busy for 'hold' cycles.
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  int           hold = 10 * CPB;
  logic         ext_busy = 1'b0;
  byte unsigned sent[$];
  int unsigned  fall_edge = 0;

  assign tx_busy = m_busy | ext_busy;

  always @(posedge clk) begin
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy    <= 1'b0;
        // The DUT first samples busy low on the following edge.
        fall_edge <= cyc + 2;
      end
    end else if (tx_start && !tx_busy) begin
      sent.push_back(tx_data);
      m_busy <= 1'b1;
      m_cnt  <= hold;
    end
  end

  byte unsigned pay[$];
  byte unsigned expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: payload in order, plus XOR trailer when checksum is built in.
  task automatic build_expected();
    byte unsigned x;
    x = 8'h00;
    expq = pay;
    foreach (pay[i]) x = x ^ pay[i];
`ifdef UART_PKT_TX_CHKSUM_EN
    expq.push_back(x);
`endif
  endtask

  task automatic write_packet(input bit terminate);
    for (int i = 0; i < pay.size(); i++) begin
      @(negedge clk);
      chk($sformatf("wr_ready_fill[%0d]", i), {31'd0, wr_ready}, 32'd1);
      wr_en   = 1'b1;
      wr_data = pay[i];
      wr_last = terminate && (i == pay.size() - 1);
    end
    @(negedge clk);
    wr_en   = 1'b0;
    wr_last = 1'b0;
    chk("wr_ready_after_commit", {31'd0, wr_ready}, 32'd0);
  endtask

  task automatic wait_done(input bit junk);
    int          n;
    bit          done;
    int unsigned done_cyc;
    int          viol;
    n = 0; done = 1'b0; done_cyc = 0; viol = 0;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      if (pkt_done) begin
        done     = 1'b1;
        done_cyc = cyc;
        wr_en    = 1'b0;
      end else begin
        if (wr_ready) viol++;
        if (junk && $urandom_range(0, 3) == 0) begin
          wr_en   = 1'b1;
          wr_data = 8'hFF;
          wr_last = 1'($urandom);
        end else begin
          wr_en   = 1'b0;
          wr_last = 1'b0;
        end
      end
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
    chk("pkt_done_seen", {31'd0, done}, 32'd1);
    chk("wr_ready_low_while_sending", viol, 32'd0);
    chk("wr_ready_with_pkt_done", {31'd0, wr_ready}, 32'd1);
    chk("gap_timing", done_cyc - fall_edge, GAP_CYC + 1);
    chk("sent_count", sent.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      chk($sformatf("sent_byte[%0d]", i),
          (i < sent.size()) ? {24'd0, sent[i]} : 32'hFFFF_FFFF, {24'd0, expq[i]});
    end
    @(negedge clk);
    chk("pkt_done_one_cycle", {31'd0, pkt_done}, 32'd0);
  endtask

  task automatic run_packet(input bit terminate, input bit junk);
    build_expected();
    sent.delete();
    write_packet(terminate);
    wait_done(junk);
  endtask

  initial begin
    int  cnt;
    bit  found;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Three-byte packet with a full-character busy time
    hold = 10 * CPB;
    pay = '{8'h41, 8'h42, 8'h43};
    run_packet(1'b1, 1'b0);

    // Forced commit on the buffer limit, writes pulsed while busy
    hold = $urandom_range(2, 12);
    pay.delete();
    for (int i = 0; i < LIMIT; i++) pay.push_back(8'(i));
    run_packet(1'b0, 1'b1);

    // Random packets with random busy times and ignored writes
    repeat (4) begin
      hold = $urandom_range(1, 30);
      pay.delete();
      cnt = $urandom_range(1, 12);
      for (int i = 0; i < cnt; i++) pay.push_back(8'($urandom));
      run_packet(1'b1, 1'b1);
    end

    // uart_tx already busy when the send starts
    hold = $urandom_range(3, 20);
    pay = '{8'($urandom), 8'($urandom)};
    build_expected();
    sent.delete();
    ext_busy = 1'b1;
    write_packet(1'b1);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_start) cnt++;
    end
    chk("start_held_off", cnt, 32'd0);
    ext_busy = 1'b0;
    @(negedge clk);
    chk("start_after_release", {31'd0, tx_start}, 32'd1);
    wait_done(1'b0);

    // Reset during the second byte's handshake completion wait
    hold = 10 * CPB;
    pay = '{8'($urandom), 8'($urandom), 8'($urandom)};
    sent.delete();
    write_packet(1'b1);
    found = 1'b0;
    for (int n = 0; n < TIMEOUT && !found; n++) begin
      @(negedge clk);
      if (sent.size() == 2 && !tx_start && tx_busy) found = 1'b1;
    end
    chk("reached_second_ack", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("midrst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (hold + GAP_CYC + 50) begin
      @(negedge clk);
      if (pkt_done) cnt++;
    end
    chk("midrst_no_pkt_done", cnt, 32'd0);
    chk("midrst_no_more_bytes", sent.size(), 32'd2);
    pay = '{8'h55};
    run_packet(1'b1, 1'b0);

    // Checksum pattern (trailer expected only when the option is built in)
    hold = $urandom_range(2, 12);
    pay = '{8'h01, 8'h02, 8'h04};
    run_packet(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
